stream_comp_gen_invoke: RTL and testbench

- Parametrised successor to the team's three-mode CFDF stream-compute invoke FSM.
- Per firing, executes exactly one mode, selected by next_mode_in:
  - MODE_CMD: fetch command and length.
  - MODE_DATA: fetch `length` data tokens into local RAM.
  - MODE_COMP: reduce the stored tokens with the selected operator and write one result token.
- New relative to the previous generation: generic token width and local depth, five reduction operators including saturating sum, length validation, and an error flag.
- Sits between the command/length/data input FIFOs and the result FIFO; the separate enable module uses length_out and next_mode_out.

---
 rtl/stream_comp_gen_invoke_pkg.sv | 37 +++
 rtl/stream_comp_gen_invoke_if.sv | 36 +++
 rtl/stream_comp_reduce_alu.sv | 34 +++
 rtl/stream_comp_gen_invoke.sv | 236 +++++++++++++++++++++++
 tb/tb_stream_comp_gen_invoke.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_comp_gen_invoke_pkg.sv
// Shared definitions for the stream-compute invoke block: mode and opcode
// encodings, FSM state type and an address-width helper.
package stream_comp_gen_invoke_pkg;

    localparam int unsigned MODE_W = 2;
    localparam logic [MODE_W-1:0] MODE_CMD  = 2'b00;
    localparam logic [MODE_W-1:0] MODE_DATA = 2'b01;
    localparam logic [MODE_W-1:0] MODE_COMP = 2'b10;

    // Reduction opcodes, taken from the low bits of the latched command.
    localparam int unsigned OP_W = 3;
    localparam logic [OP_W-1:0] OP_SUM    = 3'd0;
    localparam logic [OP_W-1:0] OP_SATSUM = 3'd1;
    localparam logic [OP_W-1:0] OP_MAX    = 3'd2;
    localparam logic [OP_W-1:0] OP_MIN    = 3'd3;
    localparam logic [OP_W-1:0] OP_NZCNT  = 3'd4;

    typedef enum logic [2:0] {
        StIdle,
        StCmdRd,
        StCmdLatch,
        StDataRd,
        StComp,
        StDone
    } state_e;

    // Bits needed to hold values 0..n-1; never less than 1.
    function automatic int unsigned log2_ceil(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((r < 32) && ((32'd1 << r) < n)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_comp_gen_invoke_if.sv
// Scheduler/FIFO-side bundle of the invoke block. The block itself uses the
// slave view; whatever drives the FIFO heads and invoke uses the master view.
interface stream_comp_gen_invoke_if
    import stream_comp_gen_invoke_pkg::*;
#(
    parameter int unsigned width = 16
);
    logic              invoke;
    logic [MODE_W-1:0] next_mode_in;
    logic [width-1:0]  data_in;
    logic [width-1:0]  length_in;
    logic [width-1:0]  command_in;
    logic              rd_data;
    logic              rd_length;
    logic              rd_command;
    logic              wr_result;
    logic [width-1:0]  result_out;
    logic [MODE_W-1:0] next_mode_out;
    logic [width-1:0]  length_out;
    logic              FC;
    logic              busy;
    logic              err;

    modport master (
        output invoke, next_mode_in, data_in, length_in, command_in,
        input  rd_data, rd_length, rd_command, wr_result, result_out,
               next_mode_out, length_out, FC, busy, err
    );

    modport slave (
        input  invoke, next_mode_in, data_in, length_in, command_in,
        output rd_data, rd_length, rd_command, wr_result, result_out,
               next_mode_out, length_out, FC, busy, err
    );

endinterface

// File: rtl/stream_comp_reduce_alu.sv
// One combinational reduction step: folds a token into the accumulator.
// The accumulator carries one extra bit so a saturating add can see overflow.
module stream_comp_reduce_alu
    import stream_comp_gen_invoke_pkg::*;
#(
    parameter int unsigned width = 16
) (
    input  logic [width:0]    acc_i,
    input  logic [width-1:0]  token_i,
    input  logic [OP_W-1:0]   op_i,
    output logic [width:0]    acc_o
);
    localparam int unsigned AccW = width + 1;
    localparam logic [AccW-1:0] SatMax = {1'b0, {width{1'b1}}};

    logic [AccW-1:0] tok_ext;
    logic [AccW-1:0] sum;

    // Next accumulator value for the selected operator.
    always_comb begin
        tok_ext = {1'b0, token_i};
        sum     = acc_i + tok_ext;
        acc_o   = acc_i;
        case (op_i)
            OP_SUM:    acc_o = {1'b0, sum[width-1:0]};
            OP_SATSUM: acc_o = sum[width] ? SatMax : sum;
            OP_MAX:    if (tok_ext > acc_i) acc_o = tok_ext;
            OP_MIN:    if (tok_ext < acc_i) acc_o = tok_ext;
            OP_NZCNT:  if (token_i != '0) acc_o = acc_i + AccW'(1);
            default:   acc_o = acc_i;
        endcase
    end

endmodule

// File: rtl/stream_comp_gen_invoke.sv
// CFDF stream-compute invoke FSM: each firing runs one mode (fetch command,
// fetch data into local RAM, or reduce the stored tokens into one result).
module stream_comp_gen_invoke
    import stream_comp_gen_invoke_pkg::*;
#(
    parameter int unsigned width   = 16,
    parameter int unsigned max_len = 32
) (
    input logic                     clk,
    input logic                     rst,
    stream_comp_gen_invoke_if.slave bus
);
    localparam int unsigned AW   = log2_ceil(max_len);
    localparam int unsigned CW   = log2_ceil(max_len + 1);
    localparam int unsigned AccW = width + 1;

    state_e            state_q, state_d;
    logic              rd_data_q, rd_data_d;
    logic              rd_length_q, rd_length_d;
    logic              rd_command_q, rd_command_d;
    logic              wr_result_q, wr_result_d;
    logic [width-1:0]  result_q, result_d;
    logic [MODE_W-1:0] next_mode_q, next_mode_d;
    logic [width-1:0]  length_q, length_d;
    logic [width-1:0]  command_q, command_d;
    logic              fc_q, fc_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
    logic              wr_pend_q, wr_pend_d;
    logic [AccW-1:0]   acc_q, acc_d;

    logic [width-1:0]  mem_q [max_len];
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;

    logic              len_ok;
    logic              op_ok;
    logic [OP_W-1:0]   op;
    logic [width-1:0]  token;
    logic [AccW-1:0]   acc_init;
    logic [AccW-1:0]   acc_step;

    function automatic logic length_legal(input logic [width-1:0] len);
        return (len != '0) && (32'(len) <= max_len);
    endfunction

    // Decode of latched command/length shared by the FSM.
    always_comb begin
        len_ok   = length_legal(length_q);
        op_ok    = (command_q <= width'(OP_NZCNT));
        op       = command_q[OP_W-1:0];
        token    = mem_q[cnt_q[AW-1:0]];
        acc_init = (op_ok && (op == OP_MIN)) ? {1'b0, {width{1'b1}}} : '0;
    end

    stream_comp_reduce_alu #(
        .width (width)
    ) u_alu (
        .acc_i   (acc_q),
        .token_i (token),
        .op_i    (op),
        .acc_o   (acc_step)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        rd_data_d    = 1'b0;
        rd_length_d  = 1'b0;
        rd_command_d = 1'b0;
        wr_result_d  = 1'b0;
        fc_d         = 1'b0;
        wr_pend_d    = 1'b0;
        result_d     = result_q;
        next_mode_d  = next_mode_q;
        length_d     = length_q;
        command_d    = command_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        wr_cnt_d     = wr_cnt_q;
        acc_d        = acc_q;
        mem_we       = 1'b0;
        mem_waddr    = wr_cnt_q[AW-1:0];

        unique case (state_q)
            StIdle: begin
                if (bus.invoke) begin
                    case (bus.next_mode_in)
                        MODE_CMD: begin
                            state_d      = StCmdRd;
                            rd_length_d  = 1'b1;
                            rd_command_d = 1'b1;
                            err_d        = 1'b0;
                        end
                        MODE_DATA: begin
                            if (len_ok) begin
                                state_d   = StDataRd;
                                rd_data_d = 1'b1;
                                cnt_d     = CW'(1);
                                wr_cnt_d  = '0;
                            end else begin
                                state_d = StDone;
                                fc_d    = 1'b1;
                                err_d   = 1'b1;
                            end
                        end
                        MODE_COMP: begin
                            if (len_ok) begin
                                state_d = StComp;
                                cnt_d   = '0;
                                acc_d   = acc_init;
                            end else begin
                                state_d = StDone;
                                fc_d    = 1'b1;
                                err_d   = 1'b1;
                            end
                        end
                        default: begin
                            state_d = StDone;
                            fc_d    = 1'b1;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            // Pop issued last cycle; FIFO heads become valid during this one.
            StCmdRd: state_d = StCmdLatch;
            StCmdLatch: begin
                length_d  = bus.length_in;
                command_d = bus.command_in;
                fc_d      = 1'b1;
                state_d   = StDone;
                if (length_legal(bus.length_in)) begin
                    next_mode_d = MODE_DATA;
                end else begin
                    next_mode_d = MODE_CMD;
                    err_d       = 1'b1;
                end
            end
            // Pops run ahead of writes by one cycle (FIFO read latency).
            StDataRd: begin
                if (32'(cnt_q) < 32'(length_q)) begin
                    rd_data_d = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                end
                wr_pend_d = rd_data_q;
                if (wr_pend_q) begin
                    mem_we   = 1'b1;
                    wr_cnt_d = wr_cnt_q + CW'(1);
                    if (32'(wr_cnt_q) + 32'd1 == 32'(length_q)) begin
                        state_d     = StDone;
                        fc_d        = 1'b1;
                        next_mode_d = MODE_COMP;
                    end
                end
            end
            StComp: begin
                if (32'(cnt_q) < 32'(length_q)) begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    result_d    = op_ok ? acc_q[width-1:0] : '0;
                    wr_result_d = 1'b1;
                    fc_d        = 1'b1;
                    err_d       = err_q | ~op_ok;
                    next_mode_d = MODE_CMD;
                    state_d     = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and output registers; reset aborts any firing in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            rd_data_q    <= 1'b0;
            rd_length_q  <= 1'b0;
            rd_command_q <= 1'b0;
            wr_result_q  <= 1'b0;
            result_q     <= '0;
            next_mode_q  <= MODE_CMD;
            length_q     <= '0;
            command_q    <= '0;
            fc_q         <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            wr_cnt_q     <= '0;
            wr_pend_q    <= 1'b0;
            acc_q        <= '0;
        end else begin
            state_q      <= state_d;
            rd_data_q    <= rd_data_d;
            rd_length_q  <= rd_length_d;
            rd_command_q <= rd_command_d;
            wr_result_q  <= wr_result_d;
            result_q     <= result_d;
            next_mode_q  <= next_mode_d;
            length_q     <= length_d;
            command_q    <= command_d;
            fc_q         <= fc_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            wr_pend_q    <= wr_pend_d;
            acc_q        <= acc_d;
        end
    end

    // Token RAM; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= bus.data_in;
        end
    end

    assign bus.rd_data       = rd_data_q;
    assign bus.rd_length     = rd_length_q;
    assign bus.rd_command    = rd_command_q;
    assign bus.wr_result     = wr_result_q;
    assign bus.result_out    = result_q;
    assign bus.next_mode_out = next_mode_q;
    assign bus.length_out    = length_q;
    assign bus.FC            = fc_q;
    assign bus.busy          = busy_q;
    assign bus.err           = err_q;

endmodule

// File: tb/tb_stream_comp_gen_invoke.sv
// Directed bench: a 16-bit and an 8-bit instance run in lockstep from the
// same FIFO model; the 8-bit one exposes saturation and modulo wrap.
module tb_stream_comp_gen_invoke;
    import stream_comp_gen_invoke_pkg::*;

    localparam int unsigned MaxLen = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       inv = 1'b0;
    logic [1:0] nm  = 2'b00;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stream_comp_gen_invoke_if #(.width(16)) bus16 ();
    stream_comp_gen_invoke_if #(.width(8))  bus8 ();

    stream_comp_gen_invoke #(.width(16), .max_len(MaxLen)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    stream_comp_gen_invoke #(.width(8), .max_len(MaxLen)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    // FIFO model: head updates on the edge that samples the pop.
    logic [15:0] dmem [64];
    logic [15:0] lmem [64];
    logic [15:0] cmem [64];
    logic [5:0]  dwr = '0, lwr = '0, cwr = '0;
    logic [5:0]  drd = '0, lrd = '0, crd = '0;
    logic [15:0] d_head = '0, l_head = '0, c_head = '0;

    assign bus16.invoke       = inv;
    assign bus16.next_mode_in = nm;
    assign bus16.data_in      = d_head;
    assign bus16.length_in    = l_head;
    assign bus16.command_in   = c_head;
    assign bus8.invoke        = inv;
    assign bus8.next_mode_in  = nm;
    assign bus8.data_in       = d_head[7:0];
    assign bus8.length_in     = l_head[7:0];
    assign bus8.command_in    = c_head[7:0];

    always @(posedge clk) begin
        if (bus16.rd_data) begin
            d_head <= dmem[drd];
            drd    <= drd + 6'd1;
        end
        if (bus16.rd_length) begin
            l_head <= lmem[lrd];
            lrd    <= lrd + 6'd1;
        end
        if (bus16.rd_command) begin
            c_head <= cmem[crd];
            crd    <= crd + 6'd1;
        end
    end

    // Running activity counters.
    int n_rdd = 0, n_rdl = 0, n_rdc = 0, n_wr = 0, n_fc = 0;
    always @(negedge clk) begin
        if (bus16.rd_data)    n_rdd <= n_rdd + 1;
        if (bus16.rd_length)  n_rdl <= n_rdl + 1;
        if (bus16.rd_command) n_rdc <= n_rdc + 1;
        if (bus16.wr_result)  n_wr  <= n_wr + 1;
        if (bus16.FC)         n_fc  <= n_fc + 1;
    end

    int          lat;
    logic        fc_wr;
    logic [15:0] fc_res16;
    logic [7:0]  fc_res8;

    task automatic push_cmd(input logic [15:0] len, input logic [15:0] cmd);
        lmem[lwr] = len;
        lwr = lwr + 6'd1;
        cmem[cwr] = cmd;
        cwr = cwr + 6'd1;
    endtask

    task automatic push_data(input logic [15:0] v);
        dmem[dwr] = v;
        dwr = dwr + 6'd1;
    endtask

    // Fire one mode; lat = cycle index after E0 in which FC is seen (0 = none).
    task automatic fire(input logic [1:0] mode);
        int c;
        @(negedge clk);
        inv = 1'b1;
        nm  = mode;
        @(negedge clk);
        inv = 1'b0;
        lat = 0;
        c   = 1;
        while (lat == 0 && c <= 200) begin
            if (bus16.FC) begin
                lat      = c;
                fc_wr    = bus16.wr_result;
                fc_res16 = bus16.result_out;
                fc_res8  = bus8.result_out;
            end else begin
                @(negedge clk);
                c++;
            end
        end
        #1;
    endtask

    task automatic run_job(input logic [15:0] len, input logic [15:0] cmd, input int n,
                           input logic [15:0] d0, d1, d2, d3);
        logic [15:0] d [4];
        d = '{d0, d1, d2, d3};
        push_cmd(len, cmd);
        for (int i = 0; i < n; i++) push_data(d[i]);
        fire(MODE_CMD);
        fire(MODE_DATA);
        fire(MODE_COMP);
    endtask

    task automatic test_reset();
        logic [6:0] o;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        o = {bus16.rd_data, bus16.rd_length, bus16.rd_command, bus16.wr_result,
             bus16.FC, bus16.busy, bus16.err};
        checks++;
        if (o !== 7'b0) begin errors++; $display("FAIL reset_outs: got %b want 0", o); end
        checks++;
        if (bus16.result_out !== 16'd0) begin
            errors++; $display("FAIL reset_result: got %0d want 0", bus16.result_out);
        end
        checks++;
        if (bus16.length_out !== 16'd0) begin
            errors++; $display("FAIL reset_length: got %0d want 0", bus16.length_out);
        end
        checks++;
        if (bus16.next_mode_out !== MODE_CMD) begin
            errors++; $display("FAIL reset_next_mode: got %b want 00", bus16.next_mode_out);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mode_sequence();
        int s_l, s_c, s_d, s_fc, s_wr;
        s_l = n_rdl; s_c = n_rdc; s_d = n_rdd; s_fc = n_fc; s_wr = n_wr;
        push_cmd(16'd3, 16'd0);
        push_data(16'd5); push_data(16'd7); push_data(16'd9);
        fire(MODE_CMD);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL seq_cmd_lat: got %0d want 3", lat); end
        checks++;
        if (bus16.next_mode_out !== MODE_DATA) begin
            errors++; $display("FAIL seq_cmd_next: got %b want 01", bus16.next_mode_out);
        end
        checks++;
        if (bus16.length_out !== 16'd3) begin
            errors++; $display("FAIL seq_length_out: got %0d want 3", bus16.length_out);
        end
        checks++;
        if ((n_rdl - s_l) !== 1 || (n_rdc - s_c) !== 1) begin
            errors++; $display("FAIL seq_cmd_pops: got %0d/%0d want 1/1", n_rdl - s_l, n_rdc - s_c);
        end
        fire(MODE_DATA);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL seq_data_lat: got %0d want 5", lat); end
        checks++;
        if (bus16.next_mode_out !== MODE_COMP) begin
            errors++; $display("FAIL seq_data_next: got %b want 10", bus16.next_mode_out);
        end
        checks++;
        if ((n_rdd - s_d) !== 3) begin
            errors++; $display("FAIL seq_data_pops: got %0d want 3", n_rdd - s_d);
        end
        fire(MODE_COMP);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL seq_comp_lat: got %0d want 5", lat); end
        checks++;
        if (fc_wr !== 1'b1 || fc_res16 !== 16'd21) begin
            errors++; $display("FAIL seq_result: got wr=%b res=%0d want wr=1 res=21", fc_wr, fc_res16);
        end
        checks++;
        if (bus16.next_mode_out !== MODE_CMD) begin
            errors++; $display("FAIL seq_comp_next: got %b want 00", bus16.next_mode_out);
        end
        checks++;
        if ((n_fc - s_fc) !== 3 || (n_wr - s_wr) !== 1) begin
            errors++; $display("FAIL seq_fc_wr_count: got fc=%0d wr=%0d want 3/1", n_fc - s_fc, n_wr - s_wr);
        end
    endtask

    task automatic test_satsum();
        run_job(16'd2, 16'd1, 2, 16'd200, 16'd100, 16'd0, 16'd0);
        checks++;
        if (fc_res8 !== 8'd255) begin errors++; $display("FAIL satsum8: got %0d want 255", fc_res8); end
        checks++;
        if (fc_res16 !== 16'd300) begin errors++; $display("FAIL satsum16: got %0d want 300", fc_res16); end
        run_job(16'd2, 16'd0, 2, 16'd200, 16'd100, 16'd0, 16'd0);
        checks++;
        if (fc_res8 !== 8'd44) begin errors++; $display("FAIL modsum8: got %0d want 44", fc_res8); end
        checks++;
        if (fc_res16 !== 16'd300) begin errors++; $display("FAIL modsum16: got %0d want 300", fc_res16); end
    endtask

    task automatic test_max_min_cnt();
        logic [15:0] exp_r [3];
        int          s_d;
        exp_r = '{16'd12, 16'd0, 16'd3};
        for (int i = 0; i < 3; i++) begin
            s_d = n_rdd;
            run_job(16'd4, 16'(2 + i), 4, 16'd3, 16'd0, 16'd12, 16'd7);
            checks++;
            if (fc_res16 !== exp_r[i]) begin
                errors++; $display("FAIL reduce_op%0d: got %0d want %0d", 2 + i, fc_res16, exp_r[i]);
            end
            checks++;
            if ((n_rdd - s_d) !== 4) begin
                errors++; $display("FAIL reduce_pops_op%0d: got %0d want 4", 2 + i, n_rdd - s_d);
            end
        end
    endtask

    task automatic test_bad_length();
        int s_d, s_wr;
        s_d = n_rdd; s_wr = n_wr;
        push_cmd(16'd0, 16'd0);
        fire(MODE_CMD);
        checks++;
        if (bus16.err !== 1'b1 || bus16.next_mode_out !== MODE_CMD) begin
            errors++; $display("FAIL badlen0: got err=%b next=%b want 1/00", bus16.err, bus16.next_mode_out);
        end
        fire(MODE_DATA);
        checks++;
        if (lat !== 1 || bus16.err !== 1'b1) begin
            errors++; $display("FAIL data_len0: got lat=%0d err=%b want 1/1", lat, bus16.err);
        end
        fire(MODE_COMP);
        checks++;
        if (lat !== 1 || (n_wr - s_wr) !== 0) begin
            errors++; $display("FAIL comp_len0: got lat=%0d wr=%0d want 1/0", lat, n_wr - s_wr);
        end
        push_cmd(16'(MaxLen + 1), 16'd0);
        fire(MODE_CMD);
        checks++;
        if (bus16.err !== 1'b1 || bus16.next_mode_out !== MODE_CMD) begin
            errors++; $display("FAIL badlen33: got err=%b next=%b want 1/00", bus16.err, bus16.next_mode_out);
        end
        checks++;
        if ((n_rdd - s_d) !== 0) begin
            errors++; $display("FAIL badlen_pops: got %0d want 0", n_rdd - s_d);
        end
        push_cmd(16'd2, 16'd0);
        fire(MODE_CMD);
        checks++;
        if (bus16.err !== 1'b0 || bus16.next_mode_out !== MODE_DATA) begin
            errors++; $display("FAIL err_clear: got err=%b next=%b want 0/01", bus16.err, bus16.next_mode_out);
        end
    endtask

    task automatic test_invalid_mode_opcode();
        int s_all;
        s_all = n_rdd + n_rdl + n_rdc + n_wr;
        fire(2'b11);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL badmode_lat: got %0d want 1", lat); end
        checks++;
        if (bus16.err !== 1'b1 || bus16.next_mode_out !== MODE_DATA) begin
            errors++; $display("FAIL badmode_state: got err=%b next=%b want 1/01", bus16.err, bus16.next_mode_out);
        end
        checks++;
        if ((n_rdd + n_rdl + n_rdc + n_wr - s_all) !== 0) begin
            errors++; $display("FAIL badmode_fifo: got %0d want 0", n_rdd + n_rdl + n_rdc + n_wr - s_all);
        end
        run_job(16'd2, 16'd9, 2, 16'd4, 16'd6, 16'd0, 16'd0);
        checks++;
        if (fc_wr !== 1'b1 || fc_res16 !== 16'd0) begin
            errors++; $display("FAIL badop_result: got wr=%b res=%0d want 1/0", fc_wr, fc_res16);
        end
        checks++;
        if (bus16.err !== 1'b1) begin errors++; $display("FAIL badop_err: got %b want 1", bus16.err); end
    endtask

    task automatic test_reset_busy();
        int         s_l, s_d;
        logic [6:0] o;
        push_cmd(16'd10, 16'd0);
        fire(MODE_CMD);
        for (int i = 1; i <= 10; i++) push_data(16'(i));
        @(negedge clk);
        inv = 1'b1; nm = MODE_DATA;
        @(negedge clk);
        inv = 1'b0;
        #1;
        s_l = n_rdl;
        @(negedge clk);
        inv = 1'b1; nm = MODE_CMD;
        @(negedge clk);
        inv = 1'b0; nm = MODE_DATA;
        @(negedge clk);
        #1;
        checks++;
        if (bus16.busy !== 1'b1 || (n_rdl - s_l) !== 0) begin
            errors++; $display("FAIL busy_ignore: got busy=%b pops=%0d want 1/0", bus16.busy, n_rdl - s_l);
        end
        rst = 1'b0;
        #1;
        o = {bus16.rd_data, bus16.rd_length, bus16.rd_command, bus16.wr_result,
             bus16.FC, bus16.busy, bus16.err};
        checks++;
        if (o !== 7'b0) begin errors++; $display("FAIL midreset_outs: got %b want 0", o); end
        checks++;
        if (bus16.next_mode_out !== MODE_CMD || bus16.length_out !== 16'd0) begin
            errors++; $display("FAIL midreset_regs: got next=%b len=%0d want 00/0", bus16.next_mode_out, bus16.length_out);
        end
        s_d = n_rdd;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if ((n_rdd - s_d) !== 0 || bus16.busy !== 1'b0) begin
            errors++; $display("FAIL post_reset: got pops=%0d busy=%b want 0/0", n_rdd - s_d, bus16.busy);
        end
    endtask

    initial begin
        test_reset();
        test_mode_sequence();
        test_satsum();
        test_max_min_cnt();
        test_bad_length();
        test_invalid_mode_opcode();
        test_reset_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
